// File: rtl/rst_seq.sv
// Reset sequencer: releases N_OUT active-low domain resets in fixed order once
// PLL lock is stable, and re-sequences on lock loss or a software reset request.
module rst_seq #(
   parameter int N_OUT       = 3,
   parameter int GAP_CYCLES  = 16,
   parameter int LOCK_STABLE = 64
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             pll_lock_i,
   input  logic             sw_rst_req_i,
   output logic             sw_rst_ack_o,
   output logic [N_OUT-1:0] rst_n_o,
   output logic             ready_o,
   output logic [1:0]       state_o
);

   localparam int MAX_CNT = (GAP_CYCLES > LOCK_STABLE) ? GAP_CYCLES : LOCK_STABLE;
   localparam int CW      = $clog2(MAX_CNT + 1);
   localparam int IW      = $clog2(N_OUT + 1);

   // Compares are against "last value before the target" so the counter never
   // has to hold the target itself.
   localparam logic [CW-1:0] GAP_LAST  = CW'(GAP_CYCLES - 1);
   localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_STABLE - 1);
   localparam logic [IW-1:0] IDX_LAST  = IW'(N_OUT - 1);

   typedef enum logic [1:0] {
      LOCK_WAIT = 2'd0,
      RELEASE   = 2'd1,
      RUN       = 2'd2,
      SW_RST    = 2'd3
   } state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic [IW-1:0] idx;

   assign state_o = state;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state        <= LOCK_WAIT;
         cnt          <= '0;
         idx          <= '0;
         rst_n_o      <= '0;
         ready_o      <= 1'b0;
         sw_rst_ack_o <= 1'b0;
      end else begin
         sw_rst_ack_o <= 1'b0;
         // Lock loss overrides everything outside LOCK_WAIT, including a pending ack.
         if (state != LOCK_WAIT && !pll_lock_i) begin
            state   <= LOCK_WAIT;
            cnt     <= '0;
            idx     <= '0;
            rst_n_o <= '0;
            ready_o <= 1'b0;
         end else begin
            case (state)
               LOCK_WAIT: begin
                  if (!pll_lock_i) begin
                     cnt <= '0;
                  end else if (cnt == LOCK_LAST) begin
                     state <= RELEASE;
                     cnt   <= '0;
                     idx   <= '0;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               RELEASE: begin
                  if (cnt == GAP_LAST) begin
                     cnt <= '0;
                     idx <= idx + 1'b1;
                     for (int i = 0; i < N_OUT; i++) begin
                        if (idx == IW'(i)) rst_n_o[i] <= 1'b1;
                     end
                     if (idx == IDX_LAST) begin
                        state   <= RUN;
                        ready_o <= 1'b1;
                     end
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               RUN: begin
                  if (sw_rst_req_i) begin
                     state   <= SW_RST;
                     cnt     <= '0;
                     rst_n_o <= '0;
                     ready_o <= 1'b0;
                  end
               end
               SW_RST: begin
                  // Lock is known high here; a low lock was taken by the branch above.
                  if (cnt == GAP_LAST) begin
                     sw_rst_ack_o <= 1'b1;
                     state        <= RELEASE;
                     cnt          <= '0;
                     idx          <= '0;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               default: begin
                  state <= LOCK_WAIT;
                  cnt   <= '0;
                  idx   <= '0;
               end
            endcase
         end
      end
   end

endmodule
